frame_stream_gen: RTL and testbench
===================================

# frame_stream_gen

- Synthetic grey-scale video source that drives the per-frame stream interface (vsync, href, clken, 8-bit Y) consumed by the histogram and equalization blocks.
- Generates the full frame timing (vertical sync, back porch, active lines, front porch) and one selectable test pattern.
- Serves as the on-chip stimulus source for bring-up and for checking the equalization path without a camera.

## Interface
- IMG_HDISP, 640: active pixels per line (1..2047)
- IMG_VDISP, 480: active lines per frame (1..2047)
- H_BLANK, 160: blank cycles after each line's active pixels (≥1)
- VS_LINES, 2: lines with vsync high (≥1)
- VBP_LINES, 33: blank lines after vsync (≥0)
- VFP_LINES, 10: blank lines after the active lines (≥1)
- Reset rst_n, asynchronous, active-low; clock clk.
- clk  in  1  pixel clock, one pixel per cycle
- rst_n  in  1  async active-low reset
- enable  in  1  run request, honoured only at frame boundaries
- pattern  in  2  pattern select, latched at frame start
- level  in  8  constant level for pattern 3, latched at frame start
- post_frame_vsync  out  1  high during the VS_LINES lines
- post_frame_href  out  1  high during active pixels
- post_frame_clken  out  1  pixel valid, identical to href
- post_img_Y  out  8  pixel value, 0 whenever href=0
- frame_done  out  1  one-cycle pulse on the last cycle of each frame
- frame_cnt  out  16  completed frames, wraps at 65535→0

## Operation
Line length and frame length:
- H_TOTAL = IMG_HDISP + H_BLANK cycles per line.
- V_TOTAL = VS_LINES + VBP_LINES + IMG_VDISP + VFP_LINES lines per frame.

States:
- IDLE: all stream outputs are 0.
- RUN: counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) advance every cycle. h wraps to 0 and increments v. The last cycle is h=H_TOTAL-1, v=V_TOTAL-1.

Transitions:
- IDLE→RUN when enable=1. This cycle loads h=0, v=0, and latches pattern and level.
- At the last cycle of a frame: if enable=1, restart at h=0, v=0 and relatch pattern and level. If enable=0, go to IDLE.
- Deasserting enable mid-frame has no effect until the frame completes. No partial frames are ever emitted.

Region decode (from v, h):
- vsync = (v < VS_LINES).
- Active line index y = v − VS_LINES − VBP_LINES, valid for 0 ≤ y < IMG_VDISP.
- href = clken = active line and h < IMG_HDISP. Pixel index x = h.

Patterns (computed on x, y):
- 0: horizontal ramp, Y = x[7:0].
- 1: vertical ramp, Y = y[7:0].
- 2: 8×8 checkerboard, Y = (x[3]^y[3]) ? 255 : 0.
- 3: constant, Y = latched level.

Counters:
- frame_done pulses on each frame's last cycle.
- frame_cnt increments on that same cycle.
- Both behave this way regardless of enable.

## Timing
- All outputs are registered. Reset value of every output is 0, and frame_cnt = 0.
- enable=1 sampled in IDLE at edge n → vsync=1 from edge n+1.
- All outputs reflect counter state with exactly 1 cycle of latency. vsync, href, clken and Y stay mutually aligned.
- vsync rises once per frame and falls VS_LINES·H_TOTAL cycles later.
- The first href of a frame occurs (VS_LINES+VBP_LINES)·H_TOTAL cycles after the vsync rise.
- Back-to-back frames: next vsync rise is exactly V_TOTAL·H_TOTAL cycles after the previous one, with no idle gap.
- Pattern, level or enable changes mid-frame never alter the current frame.
- rst_n assertion mid-frame forces IDLE and zero outputs immediately (asynchronous). After release, the block waits for enable.

## Structure
- Shared video package holds:
  - the pattern codes as localparams: PAT_HRAMP=0, PAT_VRAMP=1, PAT_CHECK=2, PAT_CONST=3;
  - the 8-bit pixel type shared with the histogram blocks.
- Sub-module frame_timing_ctr holds the h/v counters, the IDLE/RUN state and the region decode. It outputs h, v, vsync, active and last_cycle.
- The top level holds the pattern latch, the pattern mux, the output registers and frame_cnt.

## Test plan
Small parameters for all scenarios: HDISP=8, VDISP=4, H_BLANK=4, VS=1, VBP=1, VFP=1. This gives H_TOTAL=12 and 84 cycles per frame.

- Reset, then enable=1 held at cycle 0, pattern 0 → vsync high cycles 1–12, first href cycle 25, Y=0..7 over 8 cycles, href low 4 cycles.
- Two frames back-to-back → vsync rises at cycles 1 and 85. frame_done pulses at cycles 84 and 168. frame_cnt reads 1 then 2.
- pattern 1 → each active line carries constant Y = 0,1,2,3. pattern 2 with HDISP=16 → Y = 0×8 then 255×8 on line 0, inverted on line 8.
- Change pattern 3→0 and level 200→50 at cycle 40 → current frame all Y=200, next frame ramp.
- Drop enable at cycle 30 → frame completes through cycle 84, then outputs stay 0 and frame_cnt stays at 1.
- Pulse rst_n low at cycle 50 → all outputs 0 immediately. After release with enable=1, a fresh frame starts with vsync on the following cycle.

Source files
------------

// File: rtl/frame_stream_gen_pkg.sv
// Shared video definitions: pattern codes, pixel and counter types, and the
// per-pixel pattern generator used by the synthetic frame source.
package frame_stream_gen_pkg;

    localparam logic [1:0] PAT_HRAMP = 2'd0;
    localparam logic [1:0] PAT_VRAMP = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_CONST = 2'd3;

    localparam int unsigned CNT_W = 16;

    typedef logic [7:0]       pixel_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

    // Pixel value for pixel column x of active line y; only the low bits matter.
    function automatic pixel_t pattern_pixel(input logic [1:0] pat, input cnt_t x,
                                             input cnt_t y, input pixel_t level);
        pixel_t pix;
        case (pat)
            PAT_HRAMP: pix = x[7:0];
            PAT_VRAMP: pix = y[7:0];
            PAT_CHECK: pix = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
            PAT_CONST: pix = level;
            default:   pix = 8'h00;
        endcase
        return pix;
    endfunction

endpackage

// File: rtl/frame_stream_gen_ctr.sv
// Frame timing: IDLE/RUN state, h/v counters and region decode. Frames only
// start or stop on frame boundaries so partial frames are never produced.
module frame_timing_ctr
    import frame_stream_gen_pkg::*;
#(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int H_BLANK   = 160,
    parameter int VS_LINES  = 2,
    parameter int VBP_LINES = 33,
    parameter int VFP_LINES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output cnt_t h,
    output cnt_t v,
    output logic vsync,
    output logic active,
    output logic last_cycle,
    output logic frame_start
);

    localparam cnt_t H_LAST    = cnt_t'(IMG_HDISP + H_BLANK - 1);
    localparam cnt_t V_LAST    = cnt_t'(VS_LINES + VBP_LINES + IMG_VDISP + VFP_LINES - 1);
    localparam cnt_t VS_END    = cnt_t'(VS_LINES);
    localparam cnt_t ACT_START = cnt_t'(VS_LINES + VBP_LINES);
    localparam cnt_t ACT_END   = cnt_t'(VS_LINES + VBP_LINES + IMG_VDISP);
    localparam cnt_t H_ACT_END = cnt_t'(IMG_HDISP);

    run_state_e state_r, state_nxt_s;
    cnt_t       h_r, h_nxt_s;
    cnt_t       v_r, v_nxt_s;
    logic       run_s;
    logic       last_s;
    logic       start_s;

    assign run_s  = (state_r == ST_RUN);
    assign last_s = run_s && (h_r == H_LAST) && (v_r == V_LAST);

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            h_r     <= '0;
            v_r     <= '0;
        end else begin
            state_r <= state_nxt_s;
            h_r     <= h_nxt_s;
            v_r     <= v_nxt_s;
        end
    end

    // Next-state and counter advance; a new frame always restarts at h=0, v=0.
    always_comb begin
        state_nxt_s = state_r;
        h_nxt_s     = h_r;
        v_nxt_s     = v_r;
        start_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt_s = ST_RUN;
                    h_nxt_s     = '0;
                    v_nxt_s     = '0;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    h_nxt_s = '0;
                    v_nxt_s = '0;
                    if (enable) begin
                        state_nxt_s = ST_RUN;
                        start_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (h_r == H_LAST) begin
                    h_nxt_s = '0;
                    v_nxt_s = v_r + cnt_t'(1);
                end else begin
                    h_nxt_s = h_r + cnt_t'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                h_nxt_s     = '0;
                v_nxt_s     = '0;
            end
        endcase
    end

    assign h           = h_r;
    assign v           = v_r;
    assign vsync       = run_s && (v_r < VS_END);
    assign active      = run_s && (v_r >= ACT_START) && (v_r < ACT_END) && (h_r < H_ACT_END);
    assign last_cycle  = last_s;
    assign frame_start = start_s;

endmodule

// File: rtl/frame_stream_gen.sv
// Synthetic grey-scale frame source: pattern latch, pattern mux, registered
// stream outputs and completed-frame counter on top of the timing counters.
module frame_stream_gen
    import frame_stream_gen_pkg::*;
#(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int H_BLANK   = 160,
    parameter int VS_LINES  = 2,
    parameter int VBP_LINES = 33,
    parameter int VFP_LINES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  pattern,
    input  logic [7:0]  level,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [7:0]  post_img_Y,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam cnt_t ACT_START = cnt_t'(VS_LINES + VBP_LINES);

    cnt_t       h_s;
    cnt_t       v_s;
    cnt_t       y_line_s;
    logic       vsync_s;
    logic       active_s;
    logic       last_s;
    logic       start_s;
    logic [1:0] pat_r;
    pixel_t     level_r;
    pixel_t     pix_s;

    frame_timing_ctr #(
        .IMG_HDISP (IMG_HDISP),
        .IMG_VDISP (IMG_VDISP),
        .H_BLANK   (H_BLANK),
        .VS_LINES  (VS_LINES),
        .VBP_LINES (VBP_LINES),
        .VFP_LINES (VFP_LINES)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .h           (h_s),
        .v           (v_s),
        .vsync       (vsync_s),
        .active      (active_s),
        .last_cycle  (last_s),
        .frame_start (start_s)
    );

    // Pattern and level are frozen for the whole frame from its first cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_r   <= PAT_HRAMP;
            level_r <= 8'h00;
        end else if (start_s) begin
            pat_r   <= pattern;
            level_r <= level;
        end else begin
            pat_r   <= pat_r;
            level_r <= level_r;
        end
    end

    assign y_line_s = v_s - ACT_START;

    // Pixel value; forced to zero outside the active window.
    always_comb begin
        pix_s = 8'h00;
        if (active_s) begin
            pix_s = pattern_pixel(pat_r, h_s, y_line_s, level_r);
        end else begin
            pix_s = 8'h00;
        end
    end

    // Output registers: every stream output lags the counters by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_Y       <= 8'h00;
            frame_done       <= 1'b0;
            frame_cnt        <= 16'h0000;
        end else begin
            post_frame_vsync <= vsync_s;
            post_frame_href  <= active_s;
            post_frame_clken <= active_s;
            post_img_Y       <= pix_s;
            frame_done       <= last_s;
            if (last_s) begin
                frame_cnt <= frame_cnt + 16'd1;
            end else begin
                frame_cnt <= frame_cnt;
            end
        end
    end

endmodule

// File: tb/tb_frame_stream_gen.sv
// Bench for frame_stream_gen: a frame-position model checked every cycle on two
// instances, plus hand-computed cycle-exact expectations for each scenario.
module tb_frame_stream_gen;

    localparam int HD[2]  = '{8, 16};
    localparam int VD[2]  = '{4, 16};
    localparam int HB[2]  = '{4, 4};
    localparam int VS[2]  = '{1, 1};
    localparam int VBP[2] = '{1, 1};
    localparam int VFP[2] = '{1, 1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pat_a = 2'd0;
    logic [7:0]  lvl_a = 8'd0;
    logic [1:0]  pat_b = 2'd2;
    logic [7:0]  lvl_b = 8'd0;

    logic        vs_a, hr_a, ck_a, dn_a;
    logic [7:0]  y_a;
    logic [15:0] cnt_a;
    logic        vs_b, hr_b, ck_b, dn_b;
    logic [7:0]  y_b;
    logic [15:0] cnt_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int base = 0;

    always #5 clk = ~clk;

    frame_stream_gen #(.IMG_HDISP(8), .IMG_VDISP(4), .H_BLANK(4),
                       .VS_LINES(1), .VBP_LINES(1), .VFP_LINES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pattern(pat_a), .level(lvl_a),
        .post_frame_vsync(vs_a), .post_frame_href(hr_a), .post_frame_clken(ck_a),
        .post_img_Y(y_a), .frame_done(dn_a), .frame_cnt(cnt_a));

    frame_stream_gen #(.IMG_HDISP(16), .IMG_VDISP(16), .H_BLANK(4),
                       .VS_LINES(1), .VBP_LINES(1), .VFP_LINES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pattern(pat_b), .level(lvl_b),
        .post_frame_vsync(vs_b), .post_frame_href(hr_b), .post_frame_clken(ck_b),
        .post_img_Y(y_b), .frame_done(dn_b), .frame_cnt(cnt_b));

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int frame_len(input int i);
        return (HD[i] + HB[i]) * (VS[i] + VBP[i] + VD[i] + VFP[i]);
    endfunction

    // Expected {vsync, href, Y, frame_done} for frame position pos (-1 = idle).
    function automatic logic [10:0] model_out(input int i, input int pos,
                                              input int pat, input int lvl);
        int ht, line, col, y;
        logic vs_e, hr_e;
        logic [7:0] pix;
        if (pos < 0) return 11'd0;
        ht   = HD[i] + HB[i];
        line = pos / ht;
        col  = pos % ht;
        y    = line - VS[i] - VBP[i];
        vs_e = (line < VS[i]);
        hr_e = (y >= 0) && (y < VD[i]) && (col < HD[i]);
        pix  = 8'd0;
        if (hr_e) begin
            case (pat)
                0:       pix = 8'(col % 256);
                1:       pix = 8'(y % 256);
                2:       pix = (((col / 8) + (y / 8)) % 2 == 1) ? 8'd255 : 8'd0;
                default: pix = 8'(lvl);
            endcase
        end
        return {vs_e, hr_e, pix, (pos == frame_len(i) - 1)};
    endfunction

    int          m_pos[2];
    int          m_pat[2];
    int          m_lvl[2];
    logic [10:0] m_exp[2];
    logic [15:0] m_cnt[2];

    // Model: position within the frame, frozen pattern, expected outputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_pos[i] <= -1;
                m_pat[i] <= 0;
                m_lvl[i] <= 0;
                m_exp[i] <= 11'd0;
                m_cnt[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_exp[i] <= model_out(i, m_pos[i], m_pat[i], m_lvl[i]);
                if (m_pos[i] == frame_len(i) - 1) m_cnt[i] <= m_cnt[i] + 16'd1;
                if (m_pos[i] < 0 || m_pos[i] == frame_len(i) - 1) begin
                    if (enable) begin
                        m_pos[i] <= 0;
                        m_pat[i] <= (i == 0) ? int'(pat_a) : int'(pat_b);
                        m_lvl[i] <= (i == 0) ? int'(lvl_a) : int'(lvl_b);
                    end else begin
                        m_pos[i] <= -1;
                    end
                end else begin
                    m_pos[i] <= m_pos[i] + 1;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp = n_cmp + 1;
            if ({vs_a, hr_a, ck_a, y_a, dn_a, cnt_a} !==
                {m_exp[0][10], m_exp[0][9], m_exp[0][9], m_exp[0][8:1], m_exp[0][0], m_cnt[0]}) begin
                n_err = n_err + 1;
                $display("FAIL model_a t=%0t got vs=%b hr=%b ck=%b y=%0d dn=%b cnt=%0d expected vs=%b hr=%b y=%0d dn=%b cnt=%0d",
                         $time, vs_a, hr_a, ck_a, y_a, dn_a, cnt_a,
                         m_exp[0][10], m_exp[0][9], m_exp[0][8:1], m_exp[0][0], m_cnt[0]);
            end
            n_cmp = n_cmp + 1;
            if ({vs_b, hr_b, ck_b, y_b, dn_b, cnt_b} !==
                {m_exp[1][10], m_exp[1][9], m_exp[1][9], m_exp[1][8:1], m_exp[1][0], m_cnt[1]}) begin
                n_err = n_err + 1;
                $display("FAIL model_b t=%0t got vs=%b hr=%b ck=%b y=%0d dn=%b cnt=%0d expected vs=%b hr=%b y=%0d dn=%b cnt=%0d",
                         $time, vs_b, hr_b, ck_b, y_b, dn_b, cnt_b,
                         m_exp[1][10], m_exp[1][9], m_exp[1][8:1], m_exp[1][0], m_cnt[1]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Returns #1 after the edge that ends cycle n of the current scenario.
    task automatic at_cycle(input int n);
        while (cyc < base + n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic start_run(input logic [1:0] p, input logic [7:0] l);
        @(negedge clk);
        pat_a  = p;
        lvl_a  = l;
        enable = 1'b1;
        base   = cyc + 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {hr_a, ck_a, vs_a, dn_a, y_a, cnt_a}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Pattern 0, two back-to-back frames, then pattern 1 on frame 3
        start_run(2'd0, 8'd0);
        at_cycle(0);   chk("a_vsync_c0", vs_a, 0);
        at_cycle(1);   chk("a_vsync_c1", vs_a, 1);
        at_cycle(12);  chk("a_vsync_c12", vs_a, 1);
        at_cycle(13);  chk("a_vsync_c13", vs_a, 0);
        at_cycle(24);  chk("a_href_c24", hr_a, 0);
        at_cycle(25);  chk("a_href_c25", hr_a, 1);  chk("a_y_c25", y_a, 0);
        at_cycle(32);  chk("a_y_c32", y_a, 7);      chk("a_clken_c32", ck_a, 1);
        at_cycle(33);  chk("a_href_c33", hr_a, 0);  chk("a_y_c33", y_a, 0);
        at_cycle(36);  chk("a_href_c36", hr_a, 0);
        at_cycle(37);  chk("a_href_c37", hr_a, 1);
        at_cycle(83);  chk("a_done_c83", dn_a, 0);  chk("a_cnt_c83", cnt_a, 0);
        at_cycle(84);  chk("a_done_c84", dn_a, 1);  chk("a_cnt_c84", cnt_a, 1);
        at_cycle(85);  chk("a_vsync_c85", vs_a, 1); chk("a_done_c85", dn_a, 0);
        at_cycle(100); pat_a = 2'd1;
        at_cycle(112); chk("a_f2_ramp_c112", y_a, 3);
        at_cycle(168); chk("a_done_c168", dn_a, 1); chk("a_cnt_c168", cnt_a, 2);
        at_cycle(193); chk("a_vramp_l0", y_a, 0);
        at_cycle(205); chk("a_vramp_l1", y_a, 1);
        at_cycle(217); chk("a_vramp_l2", y_a, 2);
        at_cycle(236); chk("a_vramp_l3", y_a, 3);

        // Pattern/level change mid-frame
        do_reset();
        start_run(2'd3, 8'd200);
        at_cycle(25);  chk("c_const_c25", y_a, 200);
        at_cycle(40);  pat_a = 2'd0; lvl_a = 8'd50;
        at_cycle(50);  chk("c_const_c50", y_a, 200);
        at_cycle(61);  chk("c_const_c61", y_a, 200);
        at_cycle(109); chk("c_ramp_c109", y_a, 0);
        at_cycle(110); chk("c_ramp_c110", y_a, 1);
        at_cycle(116); chk("c_ramp_c116", y_a, 7);

        // Enable dropped mid-frame
        do_reset();
        start_run(2'd0, 8'd0);
        at_cycle(30);  enable = 1'b0;
        at_cycle(49);  chk("d_href_c49", hr_a, 1);
        at_cycle(84);  chk("d_done_c84", dn_a, 1);  chk("d_cnt_c84", cnt_a, 1);
        at_cycle(85);  chk("d_vsync_c85", vs_a, 0);
        at_cycle(109); chk("d_href_c109", hr_a, 0);
        at_cycle(150); chk("d_cnt_c150", cnt_a, 1); chk("d_vsync_c150", vs_a, 0);

        // Asynchronous reset mid-frame
        do_reset();
        start_run(2'd0, 8'd0);
        at_cycle(50);  chk("e_href_c50", hr_a, 1);
        rst_n = 1'b0;
        #1;
        chk("e_async_zero", {hr_a, ck_a, vs_a, dn_a, y_a, cnt_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        base  = cyc + 1;
        at_cycle(0);   chk("e_vsync_c0", vs_a, 0);
        at_cycle(1);   chk("e_vsync_c1", vs_a, 1);  chk("e_cnt_c1", cnt_a, 0);
        at_cycle(25);  chk("e_href_c25", hr_a, 1);  chk("e_y_c25", y_a, 0);

        // Checkerboard on the 16-wide instance (H_TOTAL = 20)
        do_reset();
        start_run(2'd0, 8'd0);
        at_cycle(20);  chk("f_vsync_c20", vs_b, 1);
        at_cycle(21);  chk("f_vsync_c21", vs_b, 0);
        at_cycle(41);  chk("f_href_c41", hr_b, 1);  chk("f_y_l0_x0", y_b, 0);
        at_cycle(48);  chk("f_y_l0_x7", y_b, 0);
        at_cycle(49);  chk("f_y_l0_x8", y_b, 255);
        at_cycle(56);  chk("f_y_l0_x15", y_b, 255);
        at_cycle(57);  chk("f_href_c57", hr_b, 0);
        at_cycle(201); chk("f_y_l8_x0", y_b, 255);
        at_cycle(208); chk("f_y_l8_x7", y_b, 255);
        at_cycle(209); chk("f_y_l8_x8", y_b, 0);

        enable = 1'b0;
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
